// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: instruction fields,
// opcodes, forward-select encodings and the shadow scoreboard entry.
package hazard_pkg;

  localparam int INSTR_W       = 19;
  localparam int REG_BITS      = 3;

  localparam int OP_MSB        = 18;
  localparam int OP_LSB        = 16;
  localparam int ARITH_IMM_BIT = 17;
  localparam int MEM_ST_BIT    = 14;
  localparam int RD_MSB        = 13;
  localparam int RD_LSB        = 11;
  localparam int RS_MSB        = 10;
  localparam int RS_LSB        = 8;
  localparam int RT_MSB        = 7;
  localparam int RT_LSB        = 5;

  localparam logic [2:0] OP_ARITH  = 3'b000;
  localparam logic [2:0] OP_MEM    = 3'b100;
  localparam logic [2:0] OP_BRANCH = 3'b101;
  localparam logic [2:0] OP_SHIFT  = 3'b110;
  localparam logic [2:0] OP_JUMP   = 3'b111;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef struct packed {
    logic                valid;
    logic [REG_BITS-1:0] rd;
    logic                we;
    logic                is_load;
    logic [REG_BITS-1:0] rs;
    logic [REG_BITS-1:0] rt;
  } shadow_t;

  // A load sitting in MEM has no result yet, so it can only forward from WB.
  function automatic logic [1:0] fwd_sel(input logic [REG_BITS-1:0] src,
                                         input shadow_t mem_e,
                                         input shadow_t wb_e);
    logic [1:0] sel;
    sel = FWD_RF;
    if (src == {REG_BITS{1'b0}}) begin
      sel = FWD_RF;
    end else if (mem_e.valid && mem_e.we && !mem_e.is_load && (mem_e.rd == src)) begin
      sel = FWD_EXMEM;
    end else if (wb_e.valid && wb_e.we && (wb_e.rd == src)) begin
      sel = FWD_MEMWB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_decode.sv
// Combinational ID-stage decode: which registers the instruction writes and reads.
// Unread sources and unwritten destinations come out as r0 so they never match.
module hazard_decode
  import hazard_pkg::*;
(
  input  logic [INSTR_W-1:0]  instr,
  output logic                we,
  output logic                is_load,
  output logic                reads_rs,
  output logic                reads_rt,
  output logic [REG_BITS-1:0] rd,
  output logic [REG_BITS-1:0] rs,
  output logic [REG_BITS-1:0] rt
);

  logic [2:0]          op_s;
  logic [REG_BITS-1:0] rd_f_s;
  logic [REG_BITS-1:0] rs_f_s;
  logic [REG_BITS-1:0] rt_f_s;
  logic                is_store_s;
  logic                unused_bits_s;

  assign op_s          = instr[OP_MSB:OP_LSB];
  assign rd_f_s        = instr[RD_MSB:RD_LSB];
  assign rs_f_s        = instr[RS_MSB:RS_LSB];
  assign rt_f_s        = instr[RT_MSB:RT_LSB];
  assign unused_bits_s = ^{instr[15], instr[4:0]};

  // Opcode class to read/write flags; a store's data register travels on the rt path.
  always_comb begin
    we         = 1'b0;
    is_load    = 1'b0;
    reads_rs   = 1'b0;
    reads_rt   = 1'b0;
    is_store_s = 1'b0;
    if (op_s[2] == OP_ARITH[2]) begin
      we       = 1'b1;
      reads_rs = 1'b1;
      reads_rt = ~instr[ARITH_IMM_BIT];
    end else begin
      case (op_s)
        OP_MEM: begin
          reads_rs = 1'b1;
          if (instr[MEM_ST_BIT]) begin
            reads_rt   = 1'b1;
            is_store_s = 1'b1;
          end else begin
            we      = 1'b1;
            is_load = 1'b1;
          end
        end
        OP_SHIFT: begin
          we       = 1'b1;
          reads_rs = 1'b1;
        end
        OP_BRANCH, OP_JUMP: we = 1'b0;
        default:            we = 1'b0;
      endcase
    end
  end

  // Field selection, zeroed when the field is not actually used.
  always_comb begin
    rd = {REG_BITS{1'b0}};
    rs = {REG_BITS{1'b0}};
    rt = {REG_BITS{1'b0}};
    if (we) begin
      rd = rd_f_s;
    end else begin
      rd = {REG_BITS{1'b0}};
    end
    if (reads_rs) begin
      rs = rs_f_s;
    end else begin
      rs = {REG_BITS{1'b0}};
    end
    if (reads_rt) begin
      rt = is_store_s ? rd_f_s : rt_f_s;
    end else begin
      rt = {REG_BITS{1'b0}};
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: shadow scoreboard of EX/MEM/WB destinations,
// load-use stall, redirect flush, memory freeze and EX operand forwarding.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_W = 3,
  parameter int CNT_W = 16
)(
  input  logic               clk,
  input  logic               reset,
  input  logic [18:0]        id_instr,
  input  logic               id_valid,
  input  logic               ex_redirect,
  input  logic               mem_busy,
  output logic               stall_pc,
  output logic               stall_ifid,
  output logic               bubble_idex,
  output logic               flush_ifid,
  output logic               flush_idex,
  output logic               freeze,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b,
  output logic [CNT_W-1:0]   stall_count
);

  logic             id_we_s;
  logic             id_is_load_s;
  logic             id_reads_rs_s;
  logic             id_reads_rt_s;
  logic [REG_W-1:0] id_rd_s;
  logic [REG_W-1:0] id_rs_s;
  logic [REG_W-1:0] id_rt_s;
  shadow_t          id_entry_s;
  shadow_t          ex_r;
  shadow_t          mem_r;
  shadow_t          wb_r;
  logic             load_use_s;
  logic             count_stall_s;
  logic [CNT_W-1:0] stall_count_r;

  hazard_decode u_decode (
    .instr    (id_instr),
    .we       (id_we_s),
    .is_load  (id_is_load_s),
    .reads_rs (id_reads_rs_s),
    .reads_rt (id_reads_rt_s),
    .rd       (id_rd_s),
    .rs       (id_rs_s),
    .rt       (id_rt_s)
  );

  assign id_entry_s = '{valid: id_valid, rd: id_rd_s, we: id_we_s, is_load: id_is_load_s,
                        rs: id_rs_s, rt: id_rt_s};

  assign load_use_s = ex_r.valid && ex_r.is_load && (ex_r.rd != {REG_W{1'b0}}) && id_valid &&
                      ((id_reads_rs_s && (id_rs_s == ex_r.rd)) ||
                       (id_reads_rt_s && (id_rt_s == ex_r.rd)));

  // Freeze overrides redirect, and redirect overrides a load-use stall.
  assign count_stall_s = load_use_s && !mem_busy && !ex_redirect;

  // Strobe and forward-select generation, all quiet while reset is held.
  always_comb begin
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    bubble_idex = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    freeze      = 1'b0;
    fwd_a       = FWD_RF;
    fwd_b       = FWD_RF;
    if (!reset) begin
      freeze = 1'b0;
    end else begin
      fwd_a = fwd_sel(ex_r.rs, mem_r, wb_r);
      fwd_b = fwd_sel(ex_r.rt, mem_r, wb_r);
      if (mem_busy) begin
        freeze     = 1'b1;
        stall_pc   = 1'b1;
        stall_ifid = 1'b1;
      end else if (ex_redirect) begin
        flush_ifid = 1'b1;
        flush_idex = 1'b1;
      end else if (load_use_s) begin
        stall_pc    = 1'b1;
        stall_ifid  = 1'b1;
        bubble_idex = 1'b1;
      end else begin
        freeze = 1'b0;
      end
    end
  end

  // Shadow scoreboard advance; a bubble or flush injects an empty EX entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_r  <= '0;
      mem_r <= '0;
      wb_r  <= '0;
    end else if (mem_busy) begin
      ex_r  <= ex_r;
      mem_r <= mem_r;
      wb_r  <= wb_r;
    end else begin
      wb_r  <= mem_r;
      mem_r <= ex_r;
      if (ex_redirect || load_use_s || !id_valid) begin
        ex_r <= '0;
      end else begin
        ex_r <= id_entry_s;
      end
    end
  end

  // Saturating count of load-use stall cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count_r <= {CNT_W{1'b0}};
    end else if (count_stall_s && (stall_count_r != {CNT_W{1'b1}})) begin
      stall_count_r <= stall_count_r + CNT_W'(1);
    end else begin
      stall_count_r <= stall_count_r;
    end
  end

  assign stall_count = stall_count_r;

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: directed per-cycle vectors push expectations,
// a negedge monitor pops and compares strobes, forward selects and stall count.
module tb_hazard_unit;

  localparam int CNT_W = 16;

  localparam logic [9:0] Z   = 10'b00_0000_0000;
  localparam logic [9:0] STL = 10'b11_1000_0000;
  localparam logic [9:0] BSY = 10'b11_0001_0000;
  localparam logic [9:0] FLS = 10'b00_0110_0000;
  localparam logic [9:0] FA1 = 10'b00_0000_0100;
  localparam logic [9:0] FA2 = 10'b00_0000_1000;
  localparam logic [9:0] FB1 = 10'b00_0000_0001;
  localparam logic [9:0] FB2 = 10'b00_0000_0010;

  typedef struct {
    logic [9:0]       bits;
    logic [CNT_W-1:0] cnt;
    string            name;
  } exp_t;

  logic             clk;
  logic             reset;
  logic [18:0]      id_instr;
  logic             id_valid;
  logic             ex_redirect;
  logic             mem_busy;
  logic             stall_pc, stall_ifid, bubble_idex, flush_ifid, flush_idex, freeze;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_count;

  exp_t q[$];
  int   n_cmp;
  int   n_bad;

  hazard_unit #(.REG_W(3), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .id_instr(id_instr), .id_valid(id_valid),
    .ex_redirect(ex_redirect), .mem_busy(mem_busy), .stall_pc(stall_pc),
    .stall_ifid(stall_ifid), .bubble_idex(bubble_idex), .flush_ifid(flush_ifid),
    .flush_idex(flush_idex), .freeze(freeze), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [18:0] enc(input logic [2:0] op, input logic b14,
                                      input logic [2:0] rd, input logic [2:0] rs,
                                      input logic [2:0] rt);
    return {op, 1'b0, b14, rd, rs, rt, 5'b00000};
  endfunction

  task automatic step(input logic rst, input logic [18:0] ins, input logic vld,
                      input logic redir, input logic busy, input logic [9:0] eb,
                      input logic [CNT_W-1:0] ec, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    reset       = rst;
    id_instr    = ins;
    id_valid    = vld;
    ex_redirect = redir;
    mem_busy    = busy;
    e.bits = eb;
    e.cnt  = ec;
    e.name = nm;
    q.push_back(e);
  endtask

  // Monitor: compares one expectation per cycle, mid-cycle.
  initial begin
    exp_t       e;
    logic [9:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e   = q.pop_front();
        act = {stall_pc, stall_ifid, bubble_idex, flush_ifid, flush_idex, freeze, fwd_a, fwd_b};
        n_cmp++;
        if (act !== e.bits || stall_count !== e.cnt) begin
          n_bad++;
          $display("FAIL %s: got {sp,si,bub,fi,fe,frz,fa,fb}=%b cnt=%0d, expected %b cnt=%0d",
                   e.name, act, stall_count, e.bits, e.cnt);
        end
      end
    end
  end

  initial begin
    logic [18:0] a1, a4, a6, l2, a3, b1, c6, z1, z2, c600, a5, s5, l5, s57, i3, nop;
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0; id_instr = 19'd0; id_valid = 1'b0; ex_redirect = 1'b0; mem_busy = 1'b0;
    nop  = 19'd0;
    a1   = enc(3'b000, 1'b0, 3'd1, 3'd2, 3'd3);
    a4   = enc(3'b000, 1'b0, 3'd4, 3'd1, 3'd5);
    a6   = enc(3'b000, 1'b0, 3'd6, 3'd7, 3'd7);
    l2   = enc(3'b100, 1'b0, 3'd2, 3'd6, 3'd0);
    a3   = enc(3'b000, 1'b0, 3'd3, 3'd2, 3'd4);
    b1   = enc(3'b000, 1'b0, 3'd1, 3'd4, 3'd5);
    c6   = enc(3'b000, 1'b0, 3'd6, 3'd1, 3'd1);
    z1   = enc(3'b000, 1'b0, 3'd0, 3'd2, 3'd3);
    z2   = enc(3'b000, 1'b0, 3'd0, 3'd4, 3'd5);
    c600 = enc(3'b000, 1'b0, 3'd6, 3'd0, 3'd0);
    a5   = enc(3'b000, 1'b0, 3'd5, 3'd1, 3'd2);
    s5   = enc(3'b100, 1'b1, 3'd5, 3'd6, 3'd0);
    l5   = enc(3'b100, 1'b0, 3'd5, 3'd6, 3'd0);
    s57  = enc(3'b100, 1'b1, 3'd5, 3'd7, 3'd0);
    i3   = enc(3'b010, 1'b0, 3'd3, 3'd4, 3'd2);

    // reset state, inputs ignored while reset is low
    step(1'b0, nop, 1'b0, 1'b0, 1'b0, Z, 16'd0, "reset_idle");
    step(1'b0, a1,  1'b1, 1'b1, 1'b1, Z, 16'd0, "reset_gates_inputs");
    // back-to-back ALU dependency, then one instruction between
    step(1'b1, a1,  1'b1, 1'b0, 1'b0, Z,   16'd0, "alu_first");
    step(1'b1, a4,  1'b1, 1'b0, 1'b0, Z,   16'd0, "alu_dep_no_stall");
    step(1'b1, nop, 1'b0, 1'b0, 1'b0, FA1, 16'd0, "fwd_exmem");
    step(1'b1, nop, 1'b0, 1'b0, 1'b0, Z,   16'd0, "drain_a");
    step(1'b1, a1,  1'b1, 1'b0, 1'b0, Z,   16'd0, "alu_first_b");
    step(1'b1, a6,  1'b1, 1'b0, 1'b0, Z,   16'd0, "independent");
    step(1'b1, a4,  1'b1, 1'b0, 1'b0, Z,   16'd0, "dep_gap1");
    step(1'b1, nop, 1'b0, 1'b0, 1'b0, FA2, 16'd0, "fwd_memwb");
    step(1'b1, nop, 1'b0, 1'b0, 1'b0, Z,   16'd0, "drain_b1");
    step(1'b1, nop, 1'b0, 1'b0, 1'b0, Z,   16'd0, "drain_b2");
    // load-use
    step(1'b1, l2,  1'b1, 1'b0, 1'b0, Z,   16'd0, "ldm");
    step(1'b1, a3,  1'b1, 1'b0, 1'b0, STL, 16'd0, "load_use_stall");
    step(1'b1, a3,  1'b1, 1'b0, 1'b0, Z,   16'd1, "post_stall");
    step(1'b1, nop, 1'b0, 1'b0, 1'b0, FA2, 16'd1, "load_fwd_memwb");
    step(1'b1, nop, 1'b0, 1'b0, 1'b0, Z,   16'd1, "drain_c1");
    step(1'b1, nop, 1'b0, 1'b0, 1'b0, Z,   16'd1, "drain_c2");
    // MEM over WB priority, r0 never forwards
    step(1'b1, a1,  1'b1, 1'b0, 1'b0, Z,         16'd1, "prio_w1");
    step(1'b1, b1,  1'b1, 1'b0, 1'b0, Z,         16'd1, "prio_w2");
    step(1'b1, c6,  1'b1, 1'b0, 1'b0, Z,         16'd1, "prio_reader");
    step(1'b1, nop, 1'b0, 1'b0, 1'b0, FA1 | FB1, 16'd1, "mem_priority");
    step(1'b1, z1,  1'b1, 1'b0, 1'b0, Z,         16'd1, "r0_w1");
    step(1'b1, z2,  1'b1, 1'b0, 1'b0, Z,         16'd1, "r0_w2");
    step(1'b1, c600,1'b1, 1'b0, 1'b0, Z,         16'd1, "r0_reader");
    step(1'b1, nop, 1'b0, 1'b0, 1'b0, Z,         16'd1, "r0_no_fwd");
    step(1'b1, nop, 1'b0, 1'b0, 1'b0, Z,         16'd1, "drain_d1");
    step(1'b1, nop, 1'b0, 1'b0, 1'b0, Z,         16'd1, "drain_d2");
    // redirect beats load-use
    step(1'b1, l2,  1'b1, 1'b0, 1'b0, Z,   16'd1, "ldm_redir");
    step(1'b1, a3,  1'b1, 1'b1, 1'b0, FLS, 16'd1, "redirect_wins");
    step(1'b1, nop, 1'b0, 1'b0, 1'b0, Z,   16'd1, "post_redirect");
    step(1'b1, nop, 1'b0, 1'b0, 1'b0, Z,   16'd1, "drain_e");
    // freeze during a pending load-use
    step(1'b1, l2,  1'b1, 1'b0, 1'b0, Z,   16'd1, "ldm_busy");
    step(1'b1, a3,  1'b1, 1'b0, 1'b1, BSY, 16'd1, "busy1");
    step(1'b1, a3,  1'b1, 1'b1, 1'b1, BSY, 16'd1, "busy2_redirect_ignored");
    step(1'b1, a3,  1'b1, 1'b0, 1'b1, BSY, 16'd1, "busy3");
    step(1'b1, a3,  1'b1, 1'b0, 1'b0, STL, 16'd1, "stall_after_busy");
    step(1'b1, a3,  1'b1, 1'b0, 1'b0, Z,   16'd2, "single_stall");
    step(1'b1, nop, 1'b0, 1'b0, 1'b0, FA2, 16'd2, "load_fwd_after_busy");
    // asynchronous reset mid-stall
    step(1'b1, l2,  1'b1, 1'b0, 1'b0, Z,   16'd2, "ldm_rst");
    step(1'b1, a3,  1'b1, 1'b0, 1'b1, BSY, 16'd2, "busy_pending");
    step(1'b0, a3,  1'b1, 1'b0, 1'b1, Z,   16'd0, "reset_mid_stall");
    step(1'b1, a3,  1'b1, 1'b0, 1'b0, Z,   16'd0, "no_stale_stall");
    step(1'b1, nop, 1'b0, 1'b0, 1'b0, Z,   16'd0, "no_stale_fwd");
    // store data forwarding and store-data load-use
    step(1'b1, a5,  1'b1, 1'b0, 1'b0, Z,   16'd0, "alu_r5");
    step(1'b1, s5,  1'b1, 1'b0, 1'b0, Z,   16'd0, "stm_r5");
    step(1'b1, nop, 1'b0, 1'b0, 1'b0, FB1, 16'd0, "stm_data_fwd");
    step(1'b1, l5,  1'b1, 1'b0, 1'b0, Z,   16'd0, "ldm_r5");
    step(1'b1, s57, 1'b1, 1'b0, 1'b0, STL, 16'd0, "load_use_stm");
    step(1'b1, s57, 1'b1, 1'b0, 1'b0, Z,   16'd1, "stm_resume");
    step(1'b1, nop, 1'b0, 1'b0, 1'b0, FB2, 16'd1, "stm_load_fwd");
    // immediate-form arithmetic does not read rt
    step(1'b1, l2,  1'b1, 1'b0, 1'b0, Z,   16'd1, "ldm_imm");
    step(1'b1, i3,  1'b1, 1'b0, 1'b0, Z,   16'd1, "imm_no_rt");

    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain: %0d expectations left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
